// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   sub_state_e      : sequencing states for the serial datapath
//   SS_DEFAULT_WIDTH : default operand/result width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  localparam int unsigned SS_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: computes x - y - bin.
// Ports:
//   x, y : minuend / subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: DIFF = A - B over WIDTH cycles.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   start    : one-cycle request; a/b sampled on the same edge
//   a, b     : minuend / subtrahend
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when diff/borrow become valid
//   diff     : A - B modulo 2^WIDTH (held until the next op completes)
//   borrow   : final borrow-out, 1 iff A < B unsigned
//   diff_bit : serial difference bit produced this cycle (0 when not busy)
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             diff_bit
);

  localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic cell_d;
  logic cell_bout;
  logic load;

  full_subtractor_cell u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starts are accepted from IDLE and from the DONE cycle, never mid-shift.
  assign load = start && (state_q != SHIFT);

  // Datapath next-state
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (load) begin
      a_sr_d = a;
      b_sr_d = b;
      br_d   = 1'b0;
      cnt_d  = '0;
    end else if (state_q == SHIFT) begin
      a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
      res_sr_d = {cell_d, res_sr_q[WIDTH-1:1]};
      br_d     = cell_bout;
      cnt_d    = cnt_q + CNT_W'(1);
      // Capture the result on the last shift edge so diff/borrow are
      // already valid in the DONE cycle and never change mid-operation.
      if (cnt_q == LAST_CNT) begin
        diff_d   = {cell_d, res_sr_q[WIDTH-1:1]};
        borrow_d = cell_bout;
      end
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q == SHIFT);
    done     = (state_q == DONE);
    diff_bit = (state_q == SHIFT) ? cell_d : 1'b0;
    diff     = diff_q;
    borrow   = borrow_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8, diff_bit8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4, diff_bit4;
  logic [3:0] diff4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] last_diff   = '0;
  logic       last_borrow = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .diff_bit(diff_bit8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .diff_bit(diff_bit4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: (WIDTH+1)-bit unsigned subtraction.
  function automatic logic [8:0] ref8(input logic [7:0] av, input logic [7:0] bv);
    return {1'b0, av} - {1'b0, bv};
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] av, input logic [3:0] bv);
    return {1'b0, av} - {1'b0, bv};
  endfunction

  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Called right after the start edge; returns in the DONE cycle.
  task automatic finish_op8(input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] r;
    r = ref8(av, bv);
    for (int i = 0; i < 8; i++) begin
      check_eq("busy8", busy8, 1'b1);
      check_eq("done8_early", done8, 1'b0);
      check_eq("diff_bit8", diff_bit8, r[i]);
      check_eq("diff8_held", diff8, last_diff);
      tick();
    end
    check_eq("done8", done8, 1'b1);
    check_eq("busy8_done", busy8, 1'b0);
    check_eq("diff8", diff8, r[7:0]);
    check_eq("borrow8", borrow8, r[8]);
    last_diff   = r[7:0];
    last_borrow = r[8];
  endtask

  task automatic full_op8(input logic [7:0] av, input logic [7:0] bv);
    start_op8(av, bv);
    finish_op8(av, bv);
    tick();
    check_eq("done8_pulse", done8, 1'b0);
    check_eq("diff8_hold", diff8, last_diff);
    check_eq("borrow8_hold", borrow8, last_borrow);
  endtask

  task automatic full_op4(input logic [3:0] av, input logic [3:0] bv);
    logic [4:0] r;
    r = ref4(av, bv);
    a4 = av; b4 = bv; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("diff_bit4", diff_bit4, r[i]);
      tick();
    end
    check_eq("done4", done4, 1'b1);
    check_eq("diff4", diff4, r[3:0]);
    check_eq("borrow4", borrow4, r[4]);
    tick();
    check_eq("done4_pulse", done4, 1'b0);
  endtask

  initial begin
    logic [7:0] ra, rb;

    // Reset state
    repeat (2) tick();
    check_eq("rst_busy", busy8, 1'b0);
    check_eq("rst_done", done8, 1'b0);
    check_eq("rst_diff", diff8, 8'd0);
    check_eq("rst_borrow", borrow8, 1'b0);
    check_eq("rst_diff_bit", diff_bit8, 1'b0);
    check_eq("rst_busy4", busy4, 1'b0);
    rst = 1'b0;
    tick();

    // Directed cases
    full_op8(8'd5, 8'd3);
    full_op8(8'd3, 8'd5);
    full_op8(8'd0, 8'd1);
    full_op8(8'd0, 8'd0);
    full_op8(8'd255, 8'd255);
    full_op8(8'd128, 8'd127);

    // Start during SHIFT is ignored
    start_op8(8'd200, 8'd100);
    tick(); tick();
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    check_eq("ign_diff_mid", diff8, last_diff);
    tick();
    start8 = 1'b0;
    repeat (5) begin
      check_eq("ign_busy", busy8, 1'b1);
      check_eq("ign_diff_mid2", diff8, last_diff);
      tick();
    end
    check_eq("ign_done", done8, 1'b1);
    check_eq("ign_diff", diff8, 8'd100);
    check_eq("ign_borrow", borrow8, 1'b0);
    last_diff = 8'd100; last_borrow = 1'b0;
    tick();
    check_eq("ign_idle", busy8, 1'b0);

    // Back-to-back: start accepted in the DONE cycle
    start_op8(8'd77, 8'd33);
    finish_op8(8'd77, 8'd33);
    start_op8(8'd10, 8'd20);
    finish_op8(8'd10, 8'd20);
    check_eq("b2b_diff", diff8, 8'd246);
    check_eq("b2b_borrow", borrow8, 1'b1);
    tick();

    // Asynchronous reset mid-operation
    start_op8(8'd200, 8'd50);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy8, 1'b0);
    check_eq("arst_done", done8, 1'b0);
    check_eq("arst_diff", diff8, 8'd0);
    check_eq("arst_borrow", borrow8, 1'b0);
    check_eq("arst_diff_bit", diff_bit8, 1'b0);
    repeat (10) begin
      tick();
      check_eq("arst_no_done", done8, 1'b0);
    end
    rst = 1'b0;
    last_diff = '0; last_borrow = 1'b0;
    tick();
    check_eq("arst_idle_done", done8, 1'b0);
    full_op8(8'd37, 8'd90);

    // Randomized sweep
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      full_op8(ra, rb);
    end

    // Exhaustive on the 4-bit instance
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        full_op4(4'(x), 4'(y));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
